// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame path: executor op codes, DDRAM row bases,
// sequencer state encoding and the ASCII constants used by host logic.
package lcd_pkg;

  // Executor command op codes
  typedef enum logic [3:0] {
    OP_CLEAR = 4'd0,
    OP_WRITE = 4'd1,
    OP_SETAD = 4'd3,
    OP_WAIT  = 4'd4
  } lcd_op_e;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_SWEEP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETAD = 3'd3,
    ST_WRITE = 3'd4,
    ST_WAIT  = 3'd5,
    ST_FIN   = 3'd6
  } seq_state_e;

  // ASCII constants
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_DIGIT0  = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  // DDRAM start address of each display row; the executor adds the 0x80 command bit
  function automatic logic [7:0] lcd_row_base(input logic [1:0] row);
    logic [7:0] base;
    case (row)
      2'd0:    base = 8'h00;
      2'd1:    base = 8'h40;
      2'd2:    base = 8'h14;
      default: base = 8'h54;
    endcase
    return base;
  endfunction

  // ASCII code of a decimal digit 0..9
  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_DIGIT0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// ROWS x COLS character store, one write port and one asynchronous read port.
// Linear index is row*COLS+col; callers keep row/col inside the declared geometry.
module lcd_frame_ram
  import lcd_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 16,
  parameter int ROW_AW = 1,
  parameter int COL_AW = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_AW-1:0] wr_row,
  input  logic [COL_AW-1:0] wr_col,
  input  logic [7:0]        wr_data,
  input  logic [ROW_AW-1:0] rd_row,
  input  logic [COL_AW-1:0] rd_col,
  output logic [7:0]        rd_data
);

  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx  = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
  assign rd_idx  = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
  assign rd_data = mem[rd_idx];

  // Single write port; contents are initialised by the sequencer's clear sweep
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Frame buffer plus replay engine: clears the buffer, initialises the panel, then
// streams SETAD/WRITE(/WAIT) commands for the whole frame on request or when dirty.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int ROW_AW     = 1,
  parameter int COL_AW     = 4,
  parameter int WAIT_AFTER = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ROW_AW-1:0] wr_row,
  input  logic [COL_AW-1:0] wr_col,
  input  logic [7:0]        wr_char,
  output logic              wr_err,
  input  logic              refresh_req,
  input  logic              auto_refresh,
  output logic              busy,
  output logic              done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [3:0]        cmd_op,
  output logic [7:0]        cmd_data
);

  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROWS - 1);
  localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(COLS - 1);
  localparam logic [ROW_AW:0]   ROW_LIM  = (ROW_AW + 1)'(ROWS);
  localparam logic [COL_AW:0]   COL_LIM  = (COL_AW + 1)'(COLS);

  seq_state_e        state;
  logic [ROW_AW-1:0] row_q;
  logic [COL_AW-1:0] col_q;
  logic [ROW_AW-1:0] row_nxt;
  logic              valid_q;
  lcd_op_e           op_q;
  logic [7:0]        data_q;
  logic              dirty;
  logic              pending;
  logic              err_q;

  logic              xfer;
  logic              wr_in_range;
  logic              host_wr;
  logic              start;

  logic              ram_we;
  logic [ROW_AW-1:0] ram_wr_row;
  logic [COL_AW-1:0] ram_wr_col;
  logic [7:0]        ram_wr_data;
  logic [COL_AW-1:0] rd_col;
  logic [7:0]        rd_data;

  assign xfer        = valid_q & cmd_ready;
  assign wr_in_range = ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_col} < COL_LIM);
  assign host_wr     = wr_en & wr_in_range & (state != ST_SWEEP);
  assign start       = (state == ST_IDLE) & (refresh_req | pending | (auto_refresh & dirty));
  assign row_nxt     = row_q + 1'b1;

  assign cmd_valid = valid_q;
  assign cmd_op    = op_q;
  assign cmd_data  = data_q;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign wr_err    = err_q;

  // Write port arbitration: the clear sweep owns the RAM, otherwise host writes
  always_comb begin
    ram_we      = host_wr;
    ram_wr_row  = wr_row;
    ram_wr_col  = wr_col;
    ram_wr_data = wr_char;
    if (state == ST_SWEEP) begin
      ram_we      = 1'b1;
      ram_wr_row  = row_q;
      ram_wr_col  = col_q;
      ram_wr_data = ASCII_SPACE;
    end
  end

  // Read-ahead: address the character that becomes the next command, so it is
  // captured into cmd_data at the moment it is issued and then held while stalled
  always_comb begin
    rd_col = '0;
    if (state == ST_WRITE && col_q != COL_LAST) begin
      rd_col = col_q + 1'b1;
    end
  end

  lcd_frame_ram #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ROW_AW (ROW_AW),
    .COL_AW (COL_AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_row  (ram_wr_row),
    .wr_col  (ram_wr_col),
    .wr_data (ram_wr_data),
    .rd_row  (row_q),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  // Host-side flags: write error pulse, dirty (host write wins over refresh start), pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      dirty   <= 1'b0;
      pending <= 1'b0;
    end else begin
      err_q <= wr_en & (~wr_in_range | (state == ST_SWEEP));
      if (host_wr) begin
        dirty <= 1'b1;
      end else if (start) begin
        dirty <= 1'b0;
      end
      if (start) begin
        pending <= 1'b0;
      end else if ((state == ST_INIT && xfer) || (refresh_req && state != ST_IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

  // Sequencer FSM with registered command outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SWEEP;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      op_q    <= OP_CLEAR;
      data_q  <= '0;
    end else begin
      case (state)
        ST_SWEEP: begin
          if (col_q == COL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_LAST) begin
              row_q   <= '0;
              state   <= ST_INIT;
              valid_q <= 1'b1;
              op_q    <= OP_CLEAR;
              data_q  <= '0;
            end else begin
              row_q <= row_nxt;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        ST_INIT: begin
          if (xfer) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            op_q    <= OP_CLEAR;
            data_q  <= '0;
          end
        end
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SETAD;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b1;
            op_q    <= OP_SETAD;
            data_q  <= lcd_row_base(2'b00);
          end
        end
        ST_SETAD: begin
          if (xfer) begin
            state  <= ST_WRITE;
            col_q  <= '0;
            op_q   <= OP_WRITE;
            data_q <= rd_data;
          end
        end
        ST_WRITE: begin
          if (xfer) begin
            if (col_q != COL_LAST) begin
              col_q  <= col_q + 1'b1;
              data_q <= rd_data;
            end else if (row_q != ROW_LAST) begin
              state  <= ST_SETAD;
              row_q  <= row_nxt;
              col_q  <= '0;
              op_q   <= OP_SETAD;
              data_q <= lcd_row_base(2'(row_nxt));
            end else if (WAIT_AFTER != 0) begin
              state  <= ST_WAIT;
              op_q   <= OP_WAIT;
              data_q <= '0;
            end else begin
              state   <= ST_FIN;
              valid_q <= 1'b0;
              op_q    <= OP_CLEAR;
              data_q  <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (xfer) begin
            state   <= ST_FIN;
            valid_q <= 1'b0;
            op_q    <= OP_CLEAR;
            data_q  <= '0;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_SWEEP;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer: boot sequence, text refresh, back-pressure,
// auto refresh, rejected writes and reset during a refresh.
module tb_lcd_frame_sequencer;
  import lcd_pkg::*;

  localparam int ROWS   = 2;
  localparam int COLS   = 16;
  localparam int ROW_AW = 2;
  localparam int COL_AW = 5;
  localparam int FRAME_CMDS = ROWS * (COLS + 1) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ROW_AW-1:0] wr_row;
  logic [COL_AW-1:0] wr_col;
  logic [7:0]        wr_char;
  logic              wr_err;
  logic              refresh_req;
  logic              auto_refresh;
  logic              busy;
  logic              done;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [7:0]        cmd_data;

  always #5 clk = ~clk;

  lcd_frame_sequencer #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .ROW_AW     (ROW_AW),
    .COL_AW     (COL_AW),
    .WAIT_AFTER (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_char      (wr_char),
    .wr_err       (wr_err),
    .refresh_req  (refresh_req),
    .auto_refresh (auto_refresh),
    .busy         (busy),
    .done         (done),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] q_op [$];
  logic [7:0] q_data [$];
  logic [7:0] fb [ROWS][COLS];
  int         cyc = 0;
  int         last_push_cyc = 0;
  int         done_cyc = 0;
  int         done_cnt = 0;
  bit         rand_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [3:0] prev_op;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive ready, monitor the link at the negedge, advance to the next negedge
  task automatic cycle();
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    if (prev_stall) begin
      check("stall_valid", 32'(cmd_valid), 32'd1);
      check("stall_op",    32'(cmd_op),    32'(prev_op));
      check("stall_data",  32'(cmd_data),  32'(prev_data));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cmd_valid && cmd_ready) begin
      q_op.push_back(cmd_op);
      q_data.push_back(cmd_data);
      last_push_cyc = cyc;
    end
    prev_stall = cmd_valid && !cmd_ready;
    prev_op    = cmd_op;
    prev_data  = cmd_data;
    @(negedge clk);
    cyc++;
  endtask

  task automatic host_write(input int unsigned r, input int unsigned c, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_row  = ROW_AW'(r);
    wr_col  = COL_AW'(c);
    wr_char = ch;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic model_blank();
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        fb[r][c] = ASCII_SPACE;
  endtask

  task automatic wait_done(input string tag, input int n);
    int target = done_cnt + n;
    int k = 0;
    while (done_cnt < target && k < 400) begin
      cycle();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  task automatic expect_idle(input string tag, input int n);
    int bad = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (busy !== 1'b0 || cmd_valid !== 1'b0) bad++;
      cycle();
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic cmp_cmd(input string tag, input int idx, input logic [3:0] op, input logic [7:0] d);
    logic [3:0] o = 'x;
    logic [7:0] v = 'x;
    if (idx < q_op.size()) begin
      o = q_op[idx];
      v = q_data[idx];
    end
    check($sformatf("%s_op[%0d]", tag, idx), 32'(o), 32'(op));
    check($sformatf("%s_data[%0d]", tag, idx), 32'(v), 32'(d));
  endtask

  // Expected frame stream from the bench's own model of the buffer
  task automatic check_stream(input string tag, input int from);
    int idx = from;
    check({tag, "_len"}, 32'(q_op.size() - from), 32'(FRAME_CMDS));
    for (int unsigned r = 0; r < ROWS; r++) begin
      cmp_cmd(tag, idx, OP_SETAD, lcd_row_base(2'(r)));
      idx++;
      for (int unsigned c = 0; c < COLS; c++) begin
        cmp_cmd(tag, idx, OP_WRITE, fb[r][c]);
        idx++;
      end
    end
    cmp_cmd(tag, idx, OP_WAIT, 8'h00);
  endtask

  // From reset release: clear sweep, CLEAR, then one blank frame
  task automatic expect_boot(input string tag, input bit try_write);
    int sweep = 0;
    int busy_low = 0;
    q_op.delete();
    q_data.delete();
    model_blank();
    while (!cmd_valid && sweep < 200) begin
      if (busy !== 1'b1) busy_low++;
      if (try_write && sweep == 1) check({tag, "_sweep_wr_err"}, 32'(wr_err), 32'd1);
      if (try_write && sweep == 0) begin
        host_write(0, 0, ASCII_UPPER_A + 8'd25);
      end else begin
        cycle();
      end
      sweep++;
    end
    check({tag, "_sweep_len"}, 32'(sweep), 32'(ROWS * COLS));
    check({tag, "_sweep_busy"}, 32'(busy_low), 32'd0);
    check({tag, "_clear_op"}, 32'(cmd_op), 32'(OP_CLEAR));
    wait_done(tag, 1);
    cmp_cmd(tag, 0, OP_CLEAR, 8'h00);
    check_stream(tag, 1);
  endtask

  initial begin
    int base;
    int req_cyc;
    int k;
    string msg;

    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_char = '0;
    refresh_req = 1'b0; auto_refresh = 1'b0; cmd_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_op",    32'(cmd_op),    32'd0);
    check("rst_data",  32'(cmd_data),  32'd0);
    check("rst_busy",  32'(busy),      32'd1);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(wr_err),    32'd0);

    // 1: boot sequence with the executor always ready
    rst = 1'b0;
    expect_boot("boot", 1'b0);
    check("boot_idle_busy", 32'(busy), 32'd0);

    // 2: text at row0 col4, request latency and frame timing, pending request while busy
    msg = "Welcome!";
    for (int unsigned i = 0; i < 8; i++) begin
      host_write(0, 4 + i, msg[i]);
      fb[0][4 + i] = msg[i];
      if (i == 0) check("wel_wr_err", 32'(wr_err), 32'd0);
    end
    expect_idle("wel_no_auto", 3);
    base = q_op.size();
    req_cyc = cyc;
    refresh_req = 1'b1;
    cycle();
    refresh_req = 1'b0;
    check("lat_busy",  32'(busy),      32'd1);
    check("lat_valid", 32'(cmd_valid), 32'd1);
    check("lat_op",    32'(cmd_op),    32'(OP_SETAD));
    repeat (3) cycle();
    refresh_req = 1'b1;
    cycle();
    refresh_req = 1'b0;
    cycle();
    refresh_req = 1'b1;
    cycle();
    refresh_req = 1'b0;
    wait_done("wel", 1);
    check("wel_frame_cycles", 32'(done_cyc - req_cyc), 32'(FRAME_CMDS + 1));
    check("wel_done_after_last", 32'(done_cyc - last_push_cyc), 32'd1);
    check_stream("wel", base);
    wait_done("pend", 1);
    check_stream("pend", base + FRAME_CMDS);
    expect_idle("pend_single", 6);

    // 3: random back-pressure, order and content unchanged
    base = q_op.size();
    rand_ready = 1'b1;
    refresh_req = 1'b1;
    cycle();
    refresh_req = 1'b0;
    wait_done("bp", 1);
    rand_ready = 1'b0;
    cmd_ready = 1'b1;
    prev_stall = 1'b0;
    check_stream("bp", base);

    // 4: auto refresh on dirty, write behind the scan triggers a second frame
    auto_refresh = 1'b1;
    expect_idle("auto_clean", 4);
    base = q_op.size();
    host_write(1, 15, ASCII_UPPER_A);
    fb[1][15] = ASCII_UPPER_A;
    k = 0;
    while (q_op.size() < base + 2 && k < 50) begin
      cycle();
      k++;
    end
    check("auto_started", 32'(q_op.size() >= base + 2), 32'd1);
    host_write(0, 0, ASCII_UPPER_A + 8'd23);
    wait_done("auto1", 1);
    check_stream("auto1", base);
    fb[0][0] = ASCII_UPPER_A + 8'd23;
    wait_done("auto2", 1);
    check_stream("auto2", base + FRAME_CMDS);
    expect_idle("auto_settled", 4);

    // 5: out-of-range writes rejected, buffer and dirty untouched
    host_write(2, 0, ascii_digit(4'd7));
    check("oor_row_err", 32'(wr_err), 32'd1);
    cycle();
    check("oor_row_err_pulse", 32'(wr_err), 32'd0);
    host_write(0, 16, ascii_digit(4'd7));
    check("oor_col_err", 32'(wr_err), 32'd1);
    expect_idle("oor_no_refresh", 6);
    base = q_op.size();
    refresh_req = 1'b1;
    cycle();
    refresh_req = 1'b0;
    wait_done("oor", 1);
    check_stream("oor", base);

    // 6: reset in the middle of row 1, full restart with a cleared buffer
    base = q_op.size();
    refresh_req = 1'b1;
    cycle();
    refresh_req = 1'b0;
    k = 0;
    while (q_op.size() < base + COLS + 4 && k < 100) begin
      cycle();
      k++;
    end
    check("mid_reached", 32'(q_op.size() >= base + COLS + 4), 32'd1);
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),      32'd1);
    rst = 1'b0;
    expect_boot("reboot", 1'b1);
    expect_idle("reboot_idle", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
